// File: rtl/pcss_link_pkg.sv
// Shared constants and helpers for the chip-link receive deserializer.
package pcss_link_pkg;

  // Link words packed into one host beat.
  localparam int LANES = 4;

  // Widest word the parity helper accepts. Narrower words are zero-extended,
  // which does not change the XOR.
  localparam int PAR_MAXW = 64;

  // Byte enables for a flushed partial beat, indexed by the number of lanes
  // filled. Index 0 never flushes, so it carries the full-beat value.
  // The table assumes 16-bit link words packed into an 8-byte beat.
  function automatic logic [7:0] keep_for_idx(input logic [1:0] idx);
    logic [7:0] keep;
    keep = 8'hFF;
    case (idx)
      2'd1:    keep = 8'h03;
      2'd2:    keep = 8'h0F;
      2'd3:    keep = 8'h3F;
      default: keep = 8'hFF;
    endcase
    return keep;
  endfunction

  // Expected parity bit for a data word: the XOR of all of its bits.
  function automatic logic calc_par(input logic [PAR_MAXW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/pcss_beat_fifo.sv
// First-word-fall-through beat FIFO between the link packer and the host
// AXI-stream port. Head data reads as zero while the FIFO is empty.
module pcss_beat_fifo
  import pcss_link_pkg::*;
#(
  parameter int WIDTH = 73,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNTW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pcss_link_deser.sv
// Chip-to-host deserializer: checks parity on 16-bit link words, packs four
// words into a 64-bit AXI-stream beat, flushes partial beats after link idle
// time and buffers beats in a FWFT FIFO.
module pcss_link_deser
  import pcss_link_pkg::*;
#(
  parameter int CHIPDATA_WIDTH = 16,
  parameter int DATA_WIDTH     = 64,
  parameter int FIFO_DEPTH     = 8,
  parameter int FLUSH_CYC      = 32,
  parameter int ERRW           = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHIPDATA_WIDTH-1:0] link_data_in,
  input  logic                      link_valid,
  input  logic                      link_par,
  output logic                      link_ready,
  output logic                      link_err,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
  input  logic                      m_axis_tready,
  output logic [ERRW-1:0]           par_err_cnt
);

  localparam int KW    = DATA_WIDTH / 8;
  localparam int EW    = DATA_WIDTH + KW + 1;
  localparam int CNTW  = $clog2(FIFO_DEPTH) + 1;
  localparam int TW    = $clog2(FLUSH_CYC + 1);
  localparam int LOW_W = DATA_WIDTH - CHIPDATA_WIDTH;
  localparam logic [TW-1:0] FLUSH_TC = TW'(FLUSH_CYC);
  localparam logic [1:0]    LAST_IDX = 2'(LANES - 1);

  logic [1:0]            idx_q;
  logic [DATA_WIDTH-1:0] asm_q;
  logic [TW-1:0]         timer_q;

  logic                  xfer;
  logic                  par_ok;
  logic                  good_xfer;
  logic                  bad_xfer;
  logic                  beat_done;
  logic                  flush_fire;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNTW-1:0]       fifo_count;
  logic [CNTW-1:0]       cnt_nxt;
  logic [EW-1:0]         push_entry;
  logic [EW-1:0]         head_entry;

  assign xfer      = link_valid && link_ready;
  assign par_ok    = (calc_par(PAR_MAXW'(link_data_in)) == link_par);
  assign good_xfer = xfer && par_ok;
  assign bad_xfer  = xfer && !par_ok;
  assign beat_done = good_xfer && (idx_q == LAST_IDX);

  // Any transfer on the expiry cycle wins over the flush.
  assign flush_fire = (idx_q != 2'd0) && !xfer && (timer_q == FLUSH_TC) && !fifo_full;

  assign fifo_push = beat_done || flush_fire;
  assign fifo_pop  = m_axis_tvalid && m_axis_tready;

  // Select the FIFO entry: a full beat closes with the live word in the top
  // lane, a flush sends the assembly register as-is (unused lanes are zero).
  always_comb begin
    push_entry = {1'b0, {KW{1'b1}}, link_data_in, asm_q[LOW_W-1:0]};
    if (flush_fire) begin
      push_entry = {1'b1, KW'(keep_for_idx(idx_q)), asm_q};
    end
  end

  // Occupancy after this edge, used to register the ready flag so the chip
  // side never sees a combinational path from tready.
  always_comb begin
    cnt_nxt = fifo_count;
    if (fifo_push && !fifo_pop) begin
      cnt_nxt = fifo_count + CNTW'(1);
    end else if (!fifo_push && fifo_pop) begin
      cnt_nxt = fifo_count - CNTW'(1);
    end
  end

  // Registered receiver-ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_ready <= 1'b0;
    end else begin
      link_ready <= (cnt_nxt != CNTW'(FIFO_DEPTH));
    end
  end

  // Lane packing: good words fill lanes in arrival order; a full beat or a
  // flush clears the assembly register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 2'd0;
      asm_q <= '0;
    end else if (good_xfer) begin
      if (idx_q == LAST_IDX) begin
        idx_q <= 2'd0;
        asm_q <= '0;
      end else begin
        asm_q[idx_q*CHIPDATA_WIDTH +: CHIPDATA_WIDTH] <= link_data_in;
        idx_q <= idx_q + 2'd1;
      end
    end else if (flush_fire) begin
      idx_q <= 2'd0;
      asm_q <= '0;
    end
  end

  // Idle timer for a held partial beat; saturates at the terminal count
  // while the FIFO has no room for the flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (xfer || (idx_q == 2'd0) || flush_fire) begin
      timer_q <= '0;
    end else if (timer_q != FLUSH_TC) begin
      timer_q <= timer_q + TW'(1);
    end
  end

  // Parity error pulse and saturating error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_err    <= 1'b0;
      par_err_cnt <= '0;
    end else begin
      link_err <= bad_xfer;
      if (bad_xfer && (par_err_cnt != '1)) begin
        par_err_cnt <= par_err_cnt + ERRW'(1);
      end
    end
  end

  pcss_beat_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_beat_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = head_entry;

endmodule
